// File: rtl/rain_debounce.sv
// Rain probe debouncer: synchronizes the raw comparator output, qualifies
// wet/dry levels with a stability counter, and reports a clean rain level,
// onset/clear pulses and a saturating count of rain onsets.
module rain_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int ON_CYCLES   = 16,
  parameter int OFF_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rain_raw,
  input  logic       enable,
  input  logic       count_clr,
  output logic       rain_sensor,
  output logic       rain_rise,
  output logic       rain_fall,
  output logic [7:0] event_count
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    DRY      = 2'd0,
    WET_PEND = 2'd1,
    WET      = 2'd2,
    DRY_PEND = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   sensor_next;
  logic                   rise_next;
  logic                   fall_next;

  // Shift the asynchronous probe signal through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rain_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DRY;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a level must hold for the full qualification window.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!enable) begin
      state_next = DRY;
      cnt_next   = CNT_ZERO;
    end else begin
      case (state)
        DRY: begin
          if (s) begin
            state_next = WET_PEND;
            cnt_next   = CNT_ONE;
          end
        end
        WET_PEND: begin
          if (!s) begin
            state_next = DRY;
            cnt_next   = CNT_ZERO;
          end else if (cnt == ON_LAST) begin
            state_next = WET;
            cnt_next   = CNT_ZERO;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        WET: begin
          if (!s) begin
            state_next = DRY_PEND;
            cnt_next   = CNT_ONE;
          end
        end
        DRY_PEND: begin
          if (s) begin
            state_next = WET;
            cnt_next   = CNT_ZERO;
          end else if (cnt == OFF_LAST) begin
            state_next = DRY;
            cnt_next   = CNT_ZERO;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = DRY;
          cnt_next   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode: the level is rain while wet or still pending dry; disable forces dry.
  always_comb begin
    sensor_next = enable && ((state == WET) || (state == DRY_PEND));
    rise_next   = sensor_next && !rain_sensor;
    fall_next   = !sensor_next && rain_sensor;
  end

  // Registered outputs; clear wins over a same-edge onset, count saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rain_sensor <= 1'b0;
      rain_rise   <= 1'b0;
      rain_fall   <= 1'b0;
      event_count <= 8'd0;
    end else begin
      rain_sensor <= sensor_next;
      rain_rise   <= rise_next;
      rain_fall   <= fall_next;
      if (count_clr) begin
        event_count <= 8'd0;
      end else if (rise_next && (event_count != 8'hFF)) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rain_debounce.sv
// Bench for rain_debounce with SYNC_STAGES=2, ON_CYCLES=4, OFF_CYCLES=8.
// Stimulus pushes the expected pulse (kind, cycle, count) into a queue; a
// monitor pops and compares every rise/fall pulse the DUT produces.
module tb_rain_debounce;

  localparam logic [1:0] RISE = 2'b10;
  localparam logic [1:0] FALL = 2'b01;

  logic       clk;
  logic       rst;
  logic       rain_raw;
  logic       enable;
  logic       count_clr;
  logic       rain_sensor;
  logic       rain_rise;
  logic       rain_fall;
  logic [7:0] event_count;

  typedef struct {
    logic [1:0] kind;
    int         cycle;
    int         count;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  rain_debounce #(
    .SYNC_STAGES(2),
    .ON_CYCLES  (4),
    .OFF_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rain_raw   (rain_raw),
    .enable     (enable),
    .count_clr  (count_clr),
    .rain_sensor(rain_sensor),
    .rain_rise  (rain_rise),
    .rain_fall  (rain_fall),
    .event_count(event_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so expected pulse times can be stated in cycles.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic raw, input logic en, input logic clr);
    rain_raw  = raw;
    enable    = en;
    count_clr = clr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input int cycle, input int count);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.count = count;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rain_rise || rain_fall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got rise=%0b fall=%0b required none (cycle %0d)",
                 rain_rise, rain_fall, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("pulse_kind", int'({rain_rise, rain_fall}), int'(e.kind));
        check_output("pulse_cycle", cyc, e.cycle);
        check_output("pulse_count", int'(event_count), e.count);
      end
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int c0;
    int exp_cnt;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    tick(2);
    check_output("reset_sensor", int'(rain_sensor), 0);
    check_output("reset_rise", int'(rain_rise), 0);
    check_output("reset_fall", int'(rain_fall), 0);
    check_output("reset_count", int'(event_count), 0);
    rst = 1'b0;
    tick(3);

    // Clean rising edge: level after 6 edges, count 1.
    c0 = cyc;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_pulse(RISE, c0 + 7, 1);
    tick(6);
    check_output("rise_latency_early", int'(rain_sensor), 0);
    tick(1);
    check_output("rise_latency_on", int'(rain_sensor), 1);
    check_output("rise_count", int'(event_count), 1);
    tick(1);
    check_output("rise_one_cycle", int'(rain_rise), 0);

    // 7-cycle dropout while wet must be ignored.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    tick(7);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("dropout_mid", int'(rain_sensor), 1);
    tick(12);
    check_output("dropout_after", int'(rain_sensor), 1);

    // Clean falling edge: level drops after 10 edges.
    c0 = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_pulse(FALL, c0 + 11, 1);
    tick(10);
    check_output("fall_latency_early", int'(rain_sensor), 1);
    tick(1);
    check_output("fall_latency_off", int'(rain_sensor), 0);

    // 3-cycle glitch while dry must be ignored.
    apply_stimulus(1'b1, 1'b1, 1'b0);
    tick(3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    tick(12);
    check_output("glitch_sensor", int'(rain_sensor), 0);
    check_output("glitch_count", int'(event_count), 1);

    // Disable while wet, then re-enable with raw still high.
    c0 = cyc;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_pulse(RISE, c0 + 7, 2);
    tick(8);
    check_output("en_wet", int'(rain_sensor), 1);
    c0 = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    expect_pulse(FALL, c0 + 1, 2);
    tick(1);
    check_output("en_off_sensor", int'(rain_sensor), 0);
    tick(3);
    check_output("en_off_hold", int'(rain_sensor), 0);
    c0 = cyc;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_pulse(RISE, c0 + 5, 3);
    tick(4);
    check_output("reenable_early", int'(rain_sensor), 0);
    tick(1);
    check_output("reenable_on", int'(rain_sensor), 1);
    check_output("reenable_count", int'(event_count), 3);

    // Return dry, then reset in the middle of a wet qualification.
    c0 = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_pulse(FALL, c0 + 11, 3);
    tick(12);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_sensor", int'(rain_sensor), 0);
    check_output("async_rst_rise", int'(rain_rise), 0);
    check_output("async_rst_fall", int'(rain_fall), 0);
    check_output("async_rst_count", int'(event_count), 0);
    tick(1);
    rst = 1'b0;
    c0 = cyc;
    expect_pulse(RISE, c0 + 7, 1);
    tick(6);
    check_output("post_rst_early", int'(rain_sensor), 0);
    tick(1);
    check_output("post_rst_on", int'(rain_sensor), 1);
    check_output("post_rst_count", int'(event_count), 1);

    // Clear, then drive past saturation.
    c0 = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_pulse(FALL, c0 + 11, 1);
    tick(12);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("clr_count", int'(event_count), 0);
    exp_cnt = 0;
    for (int i = 0; i < 257; i++) begin
      c0 = cyc;
      apply_stimulus(1'b1, 1'b1, 1'b0);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      expect_pulse(RISE, c0 + 7, exp_cnt);
      tick(8);
      c0 = cyc;
      apply_stimulus(1'b0, 1'b1, 1'b0);
      expect_pulse(FALL, c0 + 11, exp_cnt);
      tick(12);
    end
    check_output("sat_count", int'(event_count), 255);

    // Clear on the same edge as an onset wins over the increment.
    c0 = cyc;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_pulse(RISE, c0 + 7, 0);
    tick(6);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("clr_vs_rise_count", int'(event_count), 0);
    check_output("clr_vs_rise_sensor", int'(rain_sensor), 1);
    tick(2);
    check_output("clr_vs_rise_hold", int'(event_count), 0);
    c0 = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_pulse(FALL, c0 + 11, 0);
    tick(12);

    check_output("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rain_debounce.md
RAIN_DEBOUNCE -- requirements
Module: rain_debounce

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of input synchronizer flops (legal range 2..3).
REQ-002 Parameter: ON_CYCLES, 16, consecutive wet samples required to declare rain (legal range 2..65535).
REQ-003 Parameter: OFF_CYCLES, 64, consecutive dry samples required to declare dry (legal range 2..65535).
REQ-004 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: rain_raw  input  1  raw comparator output from the rain probe; asynchronous to clk, may bounce.
REQ-007 Port: enable  input  1  1 = filtering active; 0 = block forced dry.
REQ-008 Port: count_clr  input  1  synchronous clear of event_count.
REQ-009 Port: rain_sensor  output  1  registered, debounced rain level (1 = rain); feeds the alert stage's rain_sensor input.
REQ-010 Port: rain_rise  output  1  registered one-cycle pulse on each rain_sensor 0->1 transition.
REQ-011 Port: rain_fall  output  1  registered one-cycle pulse on each rain_sensor 1->0 transition.
REQ-012 Port: event_count  output  8  saturating count of rain onsets.

Function
REQ-013 rain_raw SHALL pass through a SYNC_STAGES-deep flop chain; its final-stage output "s" is the only value used by the FSM.
REQ-014 FSM states SHALL be: DRY, WET_PEND, WET, DRY_PEND; one internal stability counter, width ceil(log2(max(ON_CYCLES,OFF_CYCLES)+1)).
REQ-015 DRY: s=1 -> WET_PEND, counter=1; s=0 -> stay.
REQ-016 WET_PEND: s=0 -> DRY, counter=0; s=1 and counter=ON_CYCLES-1 -> WET; otherwise counter+1.
REQ-017 WET: s=0 -> DRY_PEND, counter=1; s=1 -> stay.
REQ-018 DRY_PEND: s=1 -> WET, counter=0; s=0 and counter=OFF_CYCLES-1 -> DRY; otherwise counter+1.
REQ-019 rain_sensor SHALL be 1 exactly when state is WET or DRY_PEND.
REQ-020 Latency: a clean raw edge sampled at edge 0 SHALL change rain_sensor at edge SYNC_STAGES+ON_CYCLES (rising) or SYNC_STAGES+OFF_CYCLES (falling).
REQ-021 Any raw pulse or dropout shorter than ON_CYCLES (rising) or OFF_CYCLES (falling) synchronized cycles SHALL NOT change rain_sensor.
REQ-022 rain_rise SHALL be 1 for exactly the one cycle in which rain_sensor first reads 1; likewise rain_fall for the first cycle reading 0; never both in the same cycle.
REQ-023 event_count SHALL increment by 1 in the cycle rain_rise is asserted, saturating at 255 (no wrap).
REQ-024 count_clr=1 SHALL set event_count to 0 on the next edge, taking priority over a simultaneous increment.
REQ-025 enable=0 SHALL, on the next edge, force state DRY, counter 0, rain_sensor 0; rain_fall SHALL pulse once if rain_sensor was 1; event_count holds; the synchronizer keeps running.
REQ-026 enable 0->1 SHALL resume from DRY; a raw level already high requires the full ON_CYCLES qualification.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) clear synchronizer flops, state=DRY, counter=0, rain_sensor=0, rain_rise=0, rain_fall=0, event_count=0.
REQ-028 Release of rst SHALL NOT generate rain_rise or rain_fall pulses; reset mid-qualification discards all partial counts.

Verification (SYNC_STAGES=2, ON_CYCLES=4, OFF_CYCLES=8)
REQ-029 rain_raw 0->1 held, sampled at edge 0 -> rain_sensor=1 from edge 6, rain_rise high only in cycle after edge 6, event_count=1.
REQ-030 rain_raw 3-cycle high glitch while dry -> rain_sensor stays 0, no pulses, event_count unchanged; 7-cycle dropout while wet -> rain_sensor stays 1.
REQ-031 Wet, rain_raw 1->0 held from edge 0 -> rain_sensor=0 from edge 10, single rain_fall pulse.
REQ-032 256 qualified rain onsets -> event_count=255 and holds; count_clr asserted in same cycle as a rain_rise -> event_count=0.
REQ-033 Wet, enable=0 -> rain_sensor=0 next edge with one rain_fall pulse; enable=1 with raw still high -> rain_sensor=1 4 edges later, event_count+1.
REQ-034 rst asserted between clock edges during WET_PEND -> all outputs 0 immediately; after release, raw high requires full 6-edge latency again.
